// File: rtl/aq32_esp_uart_bus_pkg.sv
// Shared register map, bit positions and prefetch state encoding for the
// AQ32 ESP UART bus slave; also usable by bench and firmware tooling.
package aq32_esp_uart_bus_pkg;

    localparam logic [1:0] UART_REG_STATUS = 2'd0;
    localparam logic [1:0] UART_REG_DATA   = 2'd1;
    localparam logic [1:0] UART_REG_CTRL   = 2'd2;

    localparam int UART_ST_RXVALID = 0;
    localparam int UART_ST_TXFULL  = 1;
    localparam int UART_ST_OVF     = 2;
    localparam int UART_ST_FERR    = 3;

    localparam int UART_CTRL_RXIE  = 0;
    localparam int UART_CTRL_TXIE  = 1;
    localparam int UART_CTRL_ERRIE = 2;

    localparam logic [0:0] PF_EMPTY = 1'b0;
    localparam logic [0:0] PF_FULL  = 1'b1;

    typedef struct packed {
        logic err_ie;
        logic tx_ie;
        logic rx_ie;
    } uart_ctrl_t;

    function automatic logic [31:0] uart_status_word(input logic rx_valid, input logic tx_full,
                                                     input logic ovf, input logic ferr);
        logic [31:0] w;
        w = '0;
        w[UART_ST_RXVALID] = rx_valid;
        w[UART_ST_TXFULL]  = tx_full;
        w[UART_ST_OVF]     = ovf;
        w[UART_ST_FERR]    = ferr;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_prefetch.sv
// One-entry holding stage in front of the show-ahead RX FIFO: pulls a byte
// whenever the holding register is empty and releases it on a CPU pop.
module uart_rx_prefetch
    import aq32_esp_uart_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] rxfifo_data,
    input  logic       rxfifo_empty,
    output logic       rxfifo_rd,
    input  logic       pop,
    output logic [8:0] hold_data,
    output logic       hold_valid
);

    logic [0:0] state;

    assign hold_valid = (state == PF_FULL);
    // The FIFO pop is combinational so it lands on the same edge that captures the head.
    assign rxfifo_rd  = !reset && (state == PF_EMPTY) && !rxfifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PF_EMPTY;
            hold_data <= '0;
        end else begin
            case (state)
                PF_EMPTY: begin
                    if (!rxfifo_empty) begin
                        hold_data <= rxfifo_data;
                        state     <= PF_FULL;
                    end
                end
                default: begin
                    if (pop) state <= PF_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/aq32_esp_uart_bus.sv
// CPU bus slave exposing STATUS/DATA/CTRL registers over the ESP UART FIFOs,
// with RX prefetch, TX back-pressure stall and a registered level interrupt.
module aq32_esp_uart_bus
    import aq32_esp_uart_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wrdata,
    input  logic [3:0]  bus_bytesel,
    input  logic        bus_wren,
    input  logic        bus_strobe,
    output logic        bus_wait,
    output logic [31:0] bus_rddata,
    output logic [8:0]  txfifo_data,
    output logic        txfifo_wr,
    input  logic        txfifo_full,
    input  logic [8:0]  rxfifo_data,
    output logic        rxfifo_rd,
    input  logic        rxfifo_empty,
    input  logic        rxfifo_overflow,
    input  logic        rx_framing_error,
    output logic        irq
);

    logic [1:0]  reg_sel;
    logic        phase;
    logic        rd_start;
    logic        wr_en;
    logic        wr_data;
    logic        pop;
    logic        rx_valid;
    logic [8:0]  hold;
    logic        ovf;
    logic        ferr;
    logic        clr_ovf;
    logic        clr_ferr;
    uart_ctrl_t  ctrl;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign reg_sel  = bus_addr[3:2];
    assign rd_start = bus_strobe && !bus_wren && !phase;
    assign wr_en    = bus_strobe && bus_wren && bus_bytesel[0];
    assign wr_data  = wr_en && (reg_sel == UART_REG_DATA);
    assign pop      = rd_start && (reg_sel == UART_REG_DATA);
    assign clr_ovf  = wr_en && (reg_sel == UART_REG_STATUS) && bus_wrdata[UART_ST_OVF];
    assign clr_ferr = wr_en && (reg_sel == UART_REG_STATUS) && bus_wrdata[UART_ST_FERR];

    // Reads always spend one wait cycle; DATA writes wait only on a full TX FIFO.
    assign bus_wait    = !reset && (rd_start || (wr_data && txfifo_full));
    assign txfifo_wr   = !reset && wr_data && !txfifo_full;
    assign txfifo_data = txfifo_wr ? bus_wrdata[8:0] : 9'd0;

    assign unused_bits = ^{bus_wrdata[31:9], bus_bytesel[3:1], bus_addr[1:0]};

    uart_rx_prefetch u_rx_prefetch (
        .clk          (clk),
        .reset        (reset),
        .rxfifo_data  (rxfifo_data),
        .rxfifo_empty (rxfifo_empty),
        .rxfifo_rd    (rxfifo_rd),
        .pop          (pop),
        .hold_data    (hold),
        .hold_valid   (rx_valid)
    );

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            UART_REG_STATUS: rd_mux = uart_status_word(rx_valid, txfifo_full, ovf, ferr);
            UART_REG_DATA:   rd_mux = {rx_valid, 22'd0, hold};
            UART_REG_CTRL:   rd_mux = {29'd0, ctrl};
            default:         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase      <= 1'b0;
            bus_rddata <= '0;
            ovf        <= 1'b0;
            ferr       <= 1'b0;
            ctrl       <= '0;
            irq        <= 1'b0;
        end else begin
            phase <= rd_start;
            if (rd_start) bus_rddata <= rd_mux;
            // A new event pulse wins over a coincident write-one-to-clear.
            ovf  <= (ovf && !clr_ovf) || rxfifo_overflow;
            ferr <= (ferr && !clr_ferr) || rx_framing_error;
            if (wr_en && (reg_sel == UART_REG_CTRL)) ctrl <= uart_ctrl_t'(bus_wrdata[2:0]);
            irq <= (ctrl.rx_ie && rx_valid) || (ctrl.tx_ie && !txfifo_full)
                || (ctrl.err_ie && (ovf || ferr));
        end
    end

endmodule

// File: tb/tb_aq32_esp_uart_bus.sv
// Randomized self-checking bench for aq32_esp_uart_bus: emulates the RX/TX FIFOs
// and predicts register contents, byte order and interrupt level.
module tb_aq32_esp_uart_bus;
    import aq32_esp_uart_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  bus_addr = '0;
    logic [31:0] bus_wrdata = '0;
    logic [3:0]  bus_bytesel = '0;
    logic        bus_wren = 1'b0;
    logic        bus_strobe = 1'b0;
    logic        bus_wait;
    logic [31:0] bus_rddata;
    logic [8:0]  txfifo_data;
    logic        txfifo_wr;
    logic        txfifo_full = 1'b0;
    logic [8:0]  rxfifo_data = '0;
    logic        rxfifo_rd;
    logic        rxfifo_empty = 1'b1;
    logic        rxfifo_overflow = 1'b0;
    logic        rx_framing_error = 1'b0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [8:0] rxq[$];
    logic [8:0] rx_discard;
    bit         rd_pending = 1'b0;
    int         rx_pops = 0;
    int         tx_pushes = 0;
    logic [8:0] last_tx = '0;

    localparam logic [3:0] A_STATUS = {UART_REG_STATUS, 2'b00};
    localparam logic [3:0] A_DATA   = {UART_REG_DATA, 2'b00};
    localparam logic [3:0] A_CTRL   = {UART_REG_CTRL, 2'b00};
    localparam logic [3:0] A_RSVD   = 4'hC;

    aq32_esp_uart_bus dut (
        .clk              (clk),
        .reset            (reset),
        .bus_addr         (bus_addr),
        .bus_wrdata       (bus_wrdata),
        .bus_bytesel      (bus_bytesel),
        .bus_wren         (bus_wren),
        .bus_strobe       (bus_strobe),
        .bus_wait         (bus_wait),
        .bus_rddata       (bus_rddata),
        .txfifo_data      (txfifo_data),
        .txfifo_wr        (txfifo_wr),
        .txfifo_full      (txfifo_full),
        .rxfifo_data      (rxfifo_data),
        .rxfifo_rd        (rxfifo_rd),
        .rxfifo_empty     (rxfifo_empty),
        .rxfifo_overflow  (rxfifo_overflow),
        .rx_framing_error (rx_framing_error),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    // FIFO emulation: observe strobes mid-cycle, retire popped entries just after the edge.
    always @(negedge clk) begin
        if (rxfifo_rd) begin
            rd_pending = 1'b1;
            rx_pops++;
        end
        if (txfifo_wr) begin
            tx_pushes++;
            last_tx = txfifo_data;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rd_pending && rxq.size() > 0) rx_discard = rxq.pop_front();
        rd_pending   = 1'b0;
        rxfifo_empty = (rxq.size() == 0);
        rxfifo_data  = (rxq.size() > 0) ? rxq[0] : 9'd0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data, output int waits);
        bus_addr = addr; bus_wren = 1'b0; bus_bytesel = 4'hF; bus_strobe = 1'b1;
        waits = -1; data = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!bus_wait) begin
                data = bus_rddata; waits = i;
                break;
            end
            tick();
        end
        tick();
        bus_strobe = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be,
                             output int waits);
        bus_addr = addr; bus_wrdata = data; bus_bytesel = be; bus_wren = 1'b1; bus_strobe = 1'b1;
        waits = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus_wait) begin
                waits = i;
                break;
            end
            tick();
        end
        tick();
        bus_strobe = 1'b0; bus_wren = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int w;
        reset = 1'b1;
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({irq, bus_wait, txfifo_wr, rxfifo_rd} !== 4'b0 || bus_rddata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got irq=%b wait=%b wr=%b rd=%b rddata=%0h exp all 0",
                     irq, bus_wait, txfifo_wr, rxfifo_rd, bus_rddata);
        end
        tick();
        reset = 1'b0;
        tick();
        bus_read(A_STATUS, d, w);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_status got %0h exp 0", d); end
        bus_read(A_CTRL, d, w);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl got %0h exp 0", d); end
    endtask

    task automatic test_rx_prefetch();
        logic [31:0] d;
        int w, p0;
        p0 = rx_pops;
        rxq.push_back(9'h041);
        repeat (4) tick();
        checks++;
        if (rx_pops - p0 !== 1) begin errors++; $display("FAIL rx_pop_count got %0d exp 1", rx_pops - p0); end
        bus_read(A_STATUS, d, w);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL rx_status got %0h exp 1", d); end
        bus_read(A_DATA, d, w);
        checks++;
        if (d !== 32'h8000_0041) begin errors++; $display("FAIL rx_data1 got %0h exp 80000041", d); end
        checks++;
        if (w !== 1) begin errors++; $display("FAIL rx_read_wait got %0d exp 1", w); end
        bus_read(A_DATA, d, w);
        checks++;
        if (d !== 32'h0000_0041) begin errors++; $display("FAIL rx_data2 got %0h exp 41", d); end
    endtask

    task automatic test_tx_stall();
        int p0, bad;
        p0 = tx_pushes; bad = 0;
        txfifo_full = 1'b1;
        bus_addr = A_DATA; bus_wrdata = 32'h1AB; bus_bytesel = 4'h1; bus_wren = 1'b1; bus_strobe = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus_wait !== 1'b1 || txfifo_wr !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL tx_stall_hold got %0d bad cycles exp 0", bad); end
        txfifo_full = 1'b0;
        @(negedge clk);
        checks++;
        if ({txfifo_wr, bus_wait} !== 2'b10 || txfifo_data !== 9'h1AB) begin
            errors++;
            $display("FAIL tx_accept got wr=%b wait=%b data=%0h exp wr=1 wait=0 data=1ab",
                     txfifo_wr, bus_wait, txfifo_data);
        end
        tick();
        bus_strobe = 1'b0; bus_wren = 1'b0;
        tick(); tick();
        checks++;
        if (tx_pushes - p0 !== 1) begin errors++; $display("FAIL tx_push_count got %0d exp 1", tx_pushes - p0); end
    endtask

    task automatic test_sticky();
        logic [31:0] d;
        int w;
        rxfifo_overflow = 1'b1; tick(); rxfifo_overflow = 1'b0; tick();
        rx_framing_error = 1'b1;
        bus_addr = A_STATUS; bus_wrdata = 32'h4; bus_bytesel = 4'h1; bus_wren = 1'b1; bus_strobe = 1'b1;
        tick();
        rx_framing_error = 1'b0; bus_strobe = 1'b0; bus_wren = 1'b0;
        bus_read(A_STATUS, d, w);
        checks++;
        if (d !== 32'h8) begin errors++; $display("FAIL w1c_first got %0h exp 8", d); end
        rxfifo_overflow = 1'b1;
        bus_addr = A_STATUS; bus_wrdata = 32'h4; bus_bytesel = 4'h1; bus_wren = 1'b1; bus_strobe = 1'b1;
        tick();
        rxfifo_overflow = 1'b0; bus_strobe = 1'b0; bus_wren = 1'b0;
        bus_read(A_STATUS, d, w);
        checks++;
        if (d !== 32'hC) begin errors++; $display("FAIL w1c_coincident got %0h exp c", d); end
        bus_write(A_STATUS, 32'hC, 4'h1, w);
        bus_read(A_STATUS, d, w);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL w1c_both got %0h exp 0", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic [8:0] b;
        logic [2:0] ie;
        bit found, mfull, movf, mferr, exp_irq;
        int w, ev;
        bus_write(A_CTRL, 32'h1, 4'h1, w);
        b = 9'($urandom_range(0, 511));
        rxq.push_back(b);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rxfifo_rd) begin found = 1'b1; break; end
            tick();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL irq_rx_capture got none exp rxfifo_rd pulse"); end
        tick();
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_rx_early got %b exp 0", irq); end
        tick();
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx_rise got %b exp 1", irq); end
        bus_read(A_DATA, d, w);
        checks++;
        if (d !== {1'b1, 22'd0, b}) begin errors++; $display("FAIL irq_rx_data got %0h exp %0h", d, {1'b1, 22'd0, b}); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_rx_fall got %b exp 0", irq); end
        bus_write(A_CTRL, 32'h2, 4'h1, w);
        tick();
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx got %b exp 1", irq); end
        movf = 1'b0; mferr = 1'b0;
        for (int r = 0; r < 12; r++) begin
            ie = 3'($urandom_range(0, 7));
            mfull = 1'($urandom_range(0, 1));
            ev = $urandom_range(0, 3);
            bus_write(A_CTRL, {29'd0, ie}, 4'h1, w);
            if (ev == 1) begin rxfifo_overflow = 1'b1; tick(); rxfifo_overflow = 1'b0; movf = 1'b1; end
            if (ev == 2) begin rx_framing_error = 1'b1; tick(); rx_framing_error = 1'b0; mferr = 1'b1; end
            if (ev == 3) begin bus_write(A_STATUS, 32'hC, 4'h1, w); movf = 1'b0; mferr = 1'b0; end
            txfifo_full = mfull;
            tick(); tick();
            @(negedge clk);
            exp_irq = (ie[1] && !mfull) || (ie[2] && (movf || mferr));
            checks++;
            if (irq !== exp_irq) begin errors++; $display("FAIL irq_rand got %b exp %b ie=%0h", irq, exp_irq, ie); end
            bus_read(A_STATUS, d, w);
            checks++;
            if (d !== {28'd0, mferr, movf, mfull, 1'b0}) begin
                errors++; $display("FAIL status_rand got %0h exp %0h", d, {28'd0, mferr, movf, mfull, 1'b0});
            end
        end
        txfifo_full = 1'b0;
        bus_write(A_STATUS, 32'hC, 4'h1, w);
        bus_write(A_CTRL, 32'h0, 4'h1, w);
    endtask

    task automatic test_byte_enables();
        logic [31:0] d;
        int w;
        bus_write(A_CTRL, 32'h7, 4'b1110, w);
        bus_read(A_CTRL, d, w);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL be_ctrl got %0h exp 0", d); end
        bus_write(A_RSVD, 32'hFFFF_FFFF, 4'hF, w);
        bus_read(A_RSVD, d, w);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reserved got %0h exp 0", d); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] waits;
        bit rd_ok;
        int w;
        bus_write(A_CTRL, 32'h5, 4'h1, w);
        bus_addr = A_CTRL; bus_wren = 1'b0; bus_bytesel = 4'hF; bus_strobe = 1'b1;
        rd_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            waits[i] = bus_wait;
            if (!bus_wait && bus_rddata !== 32'h5) rd_ok = 1'b0;
            tick();
        end
        bus_strobe = 1'b0;
        checks++;
        if (waits !== 4'b0101 || !rd_ok) begin
            errors++; $display("FAIL b2b_read got waits=%b data_ok=%b exp waits=0101 data_ok=1", waits, rd_ok);
        end
        bus_write(A_CTRL, 32'h0, 4'h1, w);
    endtask

    task automatic test_random_stream();
        logic [8:0] modelq[$];
        logic [8:0] b, e;
        logic [31:0] d, wd;
        logic [3:0] be;
        int n, p0, w, pushes0;
        n = $urandom_range(4, 8);
        p0 = rx_pops;
        for (int i = 0; i < n; i++) begin
            b = 9'($urandom_range(0, 511));
            rxq.push_back(b);
            modelq.push_back(b);
        end
        for (int k = 0; k < 40 && modelq.size() > 0; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            bus_read(A_DATA, d, w);
            if (d[31]) begin
                e = modelq.pop_front();
                checks++;
                if (d !== {1'b1, 22'd0, e}) begin errors++; $display("FAIL stream_byte got %0h exp %0h", d, {1'b1, 22'd0, e}); end
            end
            wd = $urandom; be = 4'($urandom_range(0, 15));
            pushes0 = tx_pushes;
            bus_write(A_DATA, wd, be, w);
            checks++;
            if (tx_pushes - pushes0 !== int'(be[0]) || (be[0] && last_tx !== wd[8:0])) begin
                errors++; $display("FAIL stream_tx got pushes=%0d data=%0h exp pushes=%0d data=%0h",
                                   tx_pushes - pushes0, last_tx, be[0], wd[8:0]);
            end
        end
        checks++;
        if (modelq.size() != 0 || rx_pops - p0 != n) begin
            errors++; $display("FAIL stream_done got left=%0d pops=%0d exp left=0 pops=%0d", modelq.size(), rx_pops - p0, n);
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [31:0] d;
        int w, p0;
        bus_write(A_CTRL, 32'h7, 4'h1, w);
        rxfifo_overflow = 1'b1; tick(); rxfifo_overflow = 1'b0;
        rxq.push_back(9'h155);
        repeat (4) tick();
        p0 = tx_pushes;
        txfifo_full = 1'b1;
        bus_addr = A_DATA; bus_wrdata = 32'h0F0; bus_bytesel = 4'h1; bus_wren = 1'b1; bus_strobe = 1'b1;
        tick(); tick();
        @(negedge clk);
        checks++;
        if (bus_wait !== 1'b1) begin errors++; $display("FAIL mid_stall_wait got %b exp 1", bus_wait); end
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({irq, bus_wait, txfifo_wr, rxfifo_rd} !== 4'b0 || bus_rddata !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got irq=%b wait=%b wr=%b rd=%b rddata=%0h exp all 0",
                     irq, bus_wait, txfifo_wr, rxfifo_rd, bus_rddata);
        end
        tick();
        bus_strobe = 1'b0; bus_wren = 1'b0;
        tick();
        reset = 1'b0;
        tick(); tick();
        bus_read(A_STATUS, d, w);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL mid_reset_status got %0h exp 2", d); end
        bus_read(A_DATA, d, w);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_hold got %0h exp 0", d); end
        bus_read(A_CTRL, d, w);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_ctrl got %0h exp 0", d); end
        checks++;
        if (tx_pushes != p0) begin errors++; $display("FAIL mid_reset_push got %0d exp 0", tx_pushes - p0); end
        txfifo_full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rx_prefetch();
        test_tx_stall();
        test_sticky();
        test_irq();
        test_byte_enables();
        test_back_to_back();
        test_random_stream();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
